// File: rtl/i2c_config_sequencer.sv
// Codec bring-up sequencer: walks a register-write table and hands each entry
// to the I2C engine as one transaction, with NACK retries, watchdogs and a gap.
module i2c_config_sequencer #(
   parameter logic [7:0] DEV_ADDR       = 8'h34,
   parameter int         NUM_ENTRIES    = 11,
   parameter int         AW             = 4,
   parameter int         MAX_RETRIES    = 2,
   parameter int         GAP_CYCLES     = 200,
   parameter int         TIMEOUT_CYCLES = 4095
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   output logic [AW-1:0] tbl_addr,
   input  logic [15:0]   tbl_data,
   output logic [8:0]    device_address,
   output logic [7:0]    i2c_reg_address,
   output logic [7:0]    i2c_data,
   input  logic [1:0]    i2c_status,
   input  logic          i2c_we,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [1:0]    error_code,
   output logic [AW-1:0] fail_index
);

   localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

   localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);
   localparam logic [AW-1:0] LAST_INDEX   = AW'(NUM_ENTRIES - 1);
   localparam logic [11:0]   TIMEOUT_LAST = 12'(TIMEOUT_CYCLES - 1);
   localparam logic [11:0]   GAP_LAST     = 12'(GAP_CYCLES - 1);

   localparam logic [2:0] IDLE        = 3'd0;
   localparam logic [2:0] LOAD        = 3'd1;
   localparam logic [2:0] REQ         = 3'd2;
   localparam logic [2:0] WAIT_ACCEPT = 3'd3;
   localparam logic [2:0] WAIT_DONE   = 3'd4;
   localparam logic [2:0] GAP         = 3'd5;
   localparam logic [2:0] DONE        = 3'd6;
   localparam logic [2:0] FAIL        = 3'd7;

   logic [2:0]    state_reg;
   logic [AW-1:0] index_reg;
   logic [RW-1:0] retry_reg;
   logic [11:0]   timer_reg;
   logic          load_wait_reg;
   logic          gap_to_load_reg;
   logic          go_reg;

   assign device_address = {go_reg, DEV_ADDR};
   assign busy = (state_reg != IDLE) && (state_reg != DONE) && (state_reg != FAIL);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg       <= IDLE;
         index_reg       <= '0;
         retry_reg       <= '0;
         timer_reg       <= '0;
         load_wait_reg   <= 1'b0;
         gap_to_load_reg <= 1'b0;
         go_reg          <= 1'b0;
         tbl_addr        <= '0;
         i2c_reg_address <= '0;
         i2c_data        <= '0;
         done            <= 1'b0;
         error           <= 1'b0;
         error_code      <= 2'b00;
         fail_index      <= '0;
      end else begin
         case (state_reg)
            IDLE, DONE, FAIL: begin
               if (start) begin
                  done          <= 1'b0;
                  error         <= 1'b0;
                  error_code    <= 2'b00;
                  index_reg     <= '0;
                  retry_reg     <= '0;
                  tbl_addr      <= '0;
                  load_wait_reg <= 1'b0;
                  state_reg     <= LOAD;
               end
            end
            LOAD: begin
               // tbl_addr moved on entry; the table answers a clock later, so
               // the bytes are captured on the second LOAD edge.
               if (!load_wait_reg) begin
                  load_wait_reg <= 1'b1;
               end else begin
                  load_wait_reg   <= 1'b0;
                  i2c_reg_address <= tbl_data[15:8];
                  i2c_data        <= tbl_data[7:0];
                  state_reg       <= REQ;
               end
            end
            REQ: begin
               go_reg    <= 1'b1;
               timer_reg <= '0;
               state_reg <= WAIT_ACCEPT;
            end
            WAIT_ACCEPT: begin
               if (i2c_status[0]) begin
                  go_reg    <= 1'b0;
                  timer_reg <= '0;
                  state_reg <= WAIT_DONE;
               end else if (timer_reg == TIMEOUT_LAST) begin
                  go_reg     <= 1'b0;
                  error      <= 1'b1;
                  error_code <= 2'b10;
                  fail_index <= index_reg;
                  state_reg  <= FAIL;
               end else begin
                  timer_reg <= timer_reg + 12'd1;
               end
            end
            WAIT_DONE: begin
               timer_reg <= timer_reg + 12'd1;
               if (i2c_we) begin
                  timer_reg <= '0;
                  if (i2c_status[1]) begin
                     if (retry_reg < RETRY_LIMIT) begin
                        retry_reg       <= retry_reg + 1'b1;
                        gap_to_load_reg <= 1'b0;
                        state_reg       <= GAP;
                     end else begin
                        error      <= 1'b1;
                        error_code <= 2'b01;
                        fail_index <= index_reg;
                        state_reg  <= FAIL;
                     end
                  end else if (index_reg == LAST_INDEX) begin
                     done      <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     index_reg       <= index_reg + 1'b1;
                     retry_reg       <= '0;
                     gap_to_load_reg <= 1'b1;
                     state_reg       <= GAP;
                  end
               end else if (timer_reg == TIMEOUT_LAST) begin
                  error      <= 1'b1;
                  error_code <= 2'b11;
                  fail_index <= index_reg;
                  state_reg  <= FAIL;
               end
            end
            GAP: begin
               if (timer_reg == GAP_LAST) begin
                  timer_reg     <= '0;
                  load_wait_reg <= 1'b0;
                  if (gap_to_load_reg) begin
                     tbl_addr  <= index_reg;
                     state_reg <= LOAD;
                  end else begin
                     state_reg <= REQ;
                  end
               end else begin
                  timer_reg <= timer_reg + 12'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: randomized engine behaviour and table contents
// checked against a request-list model, plus fixed scenarios with literal results.
module tb_i2c_config_sequencer;

   localparam int N    = 3;
   localparam int AW   = 4;
   localparam int MAXR = 2;
   localparam int GAPC = 200;
   localparam int TMO  = 4095;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start_tb = 1'b0;
   logic          start_stray = 1'b0;
   logic          start;
   logic [AW-1:0] tbl_addr;
   logic [15:0]   tbl_data;
   logic [8:0]    device_address;
   logic [7:0]    i2c_reg_address;
   logic [7:0]    i2c_data;
   logic [1:0]    i2c_status = 2'b00;
   logic          eng_we = 1'b0;
   logic          stray_we = 1'b0;
   logic          i2c_we;
   logic          busy;
   logic          done;
   logic          error;
   logic [1:0]    error_code;
   logic [AW-1:0] fail_index;

   assign start  = start_tb | start_stray;
   assign i2c_we = eng_we | stray_we;

   i2c_config_sequencer #(
      .DEV_ADDR(8'h34), .NUM_ENTRIES(N), .AW(AW), .MAX_RETRIES(MAXR),
      .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .tbl_addr(tbl_addr),
      .tbl_data(tbl_data), .device_address(device_address),
      .i2c_reg_address(i2c_reg_address), .i2c_data(i2c_data),
      .i2c_status(i2c_status), .i2c_we(i2c_we), .busy(busy), .done(done),
      .error(error), .error_code(error_code), .fail_index(fail_index)
   );

   always #5 clock = ~clock;

   // external table ROM with one clock of read latency
   logic [15:0] tbl_mem [16];
   always @(posedge clock) tbl_data <= tbl_mem[tbl_addr];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- engine model ----------------
   bit accept_en = 1'b1;
   bit we_en     = 1'b1;
   int acc_min   = 0;
   int nack_left [256];
   int eng_st    = 0;
   int eng_cnt   = 0;

   initial begin
      forever begin
         @(posedge clock); #1;
         if (!reset) begin
            eng_st = 0; eng_cnt = 0; i2c_status = 2'b00; eng_we = 1'b0;
         end else begin
            case (eng_st)
               0: if (device_address[8] && accept_en) begin
                     eng_cnt = $urandom_range(acc_min, acc_min + 3);
                     eng_st = 1;
                  end
               1: if (eng_cnt == 0) begin
                     i2c_status[0] = 1'b1;
                     eng_cnt = $urandom_range(2, 12);
                     eng_st = 2;
                  end else eng_cnt--;
               2: if (eng_cnt == 0) begin
                     if (we_en) begin
                        eng_we = 1'b1;
                        if (nack_left[i2c_reg_address] > 0) begin
                           i2c_status[1] = 1'b1;
                           nack_left[i2c_reg_address]--;
                        end
                        eng_st = 3;
                     end
                  end else eng_cnt--;
               default: begin
                  eng_we = 1'b0; i2c_status = 2'b00; eng_st = 0;
               end
            endcase
         end
      end
   end

   // ---------------- reference model ----------------
   logic [15:0] tbl [N];
   int          nacks [N];
   logic [15:0] exp_q [$];
   logic [15:0] obs_q [$];
   bit          exp_done, exp_err;
   logic [1:0]  exp_code;
   int          exp_fidx;

   task automatic build_model(input bit acc, input bit we);
      exp_q.delete();
      exp_done = 0; exp_err = 0; exp_code = 2'b00; exp_fidx = 0;
      for (int j = 0; j < N; j++) begin
         if (!acc || !we) begin
            exp_q.push_back(tbl[j]);
            exp_err = 1; exp_code = acc ? 2'b11 : 2'b10; exp_fidx = j;
            return;
         end
         for (int a = 0; a <= MAXR && a <= nacks[j]; a++) exp_q.push_back(tbl[j]);
         if (nacks[j] > MAXR) begin
            exp_err = 1; exp_code = 2'b01; exp_fidx = j;
            return;
         end
      end
      exp_done = 1;
   endtask

   // ---------------- monitor / compare ----------------
   bit prev_go = 0, prev_st0 = 0, have_we = 0;
   int cyc = 0, go_rise = 0, last_we = 0, last_go_len = 0;

   initial begin
      forever begin
         @(negedge clock);
         cyc++;
         if (!reset) begin
            prev_go = 0; prev_st0 = 0;
         end else begin
            chk("dev_addr", device_address[7:0], 8'h34);
            if (device_address[8] && !prev_go) begin
               go_rise = cyc;
               obs_q.push_back({i2c_reg_address, i2c_data});
               if (exp_q.size() == 0) chk("extra_request", {i2c_reg_address, i2c_data}, 32'hFFFF_FFFF);
               else chk("request_bytes", {i2c_reg_address, i2c_data}, exp_q.pop_front());
               if (have_we) chk("gap_ge_200", (cyc - last_we) >= GAPC, 1);
            end
            if (!device_address[8] && prev_go) last_go_len = cyc - go_rise;
            chk("go_low_after_accept", device_address[8] && i2c_status[0] && prev_st0, 0);
            if (device_address[8]) chk("busy_while_go", busy, 1);
            if (done || error) chk("idle_when_finished", busy, 0);
            if (eng_we) begin last_we = cyc; have_we = 1; end
            prev_go  = device_address[8];
            prev_st0 = i2c_status[0];
         end
      end
   end

   // ---------------- stray start / we injection ----------------
   bit stray_mode = 0;
   initial begin
      forever begin
         @(posedge device_address[8]);
         if (stray_mode) begin
            repeat (2) @(posedge clock);
            #1;
            if (device_address[8] && !i2c_status[0]) begin
               stray_we = 1'b1; @(posedge clock); #1; stray_we = 1'b0;
            end
            repeat (28) @(posedge clock);
            #1;
            if (busy) begin
               start_stray = 1'b1; @(posedge clock); #1; start_stray = 1'b0;
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic load_table();
      for (int j = 0; j < N; j++) begin
         tbl_mem[j] = tbl[j];
         nack_left[tbl[j][15:8]] = nacks[j];
      end
   endtask

   task automatic set_fixed(input int n0, input int n1, input int n2);
      tbl[0] = 16'h0F00; tbl[1] = 16'h0C00; tbl[2] = 16'h1201;
      nacks[0] = n0; nacks[1] = n1; nacks[2] = n2;
   endtask

   task automatic pulse_start();
      @(posedge clock); #1; start_tb = 1'b1;
      @(posedge clock); #1; start_tb = 1'b0;
   endtask

   task automatic run_pass(input bit acc, input bit we, input string tag);
      bit ok;
      accept_en = acc; we_en = we;
      load_table();
      build_model(acc, we);
      obs_q.delete();
      have_we = 0;
      pulse_start();
      ok = 0;
      for (int c = 0; c < 30000; c++) begin
         @(negedge clock);
         if (!busy && (done || error)) begin ok = 1; break; end
      end
      chk({tag, "_finished"}, ok, 1);
      repeat (5) @(negedge clock);
      chk({tag, "_done"}, done, exp_done);
      chk({tag, "_error"}, error, exp_err);
      chk({tag, "_error_code"}, error_code, exp_code);
      if (exp_err) chk({tag, "_fail_index"}, fail_index, exp_fidx);
      chk({tag, "_missing_requests"}, exp_q.size(), 0);
      $display("pass %s: requests=%0d done=%0b error=%0b code=%0d", tag, obs_q.size(), done, error, error_code);
   endtask

   task automatic wait_cond_addr1(output bit ok);
      ok = 0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clock);
         if (tbl_addr == 4'd1) begin ok = 1; break; end
      end
   endtask

   task automatic wait_wait_done(output bit ok);
      ok = 0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clock);
         if (i2c_status[0] && !device_address[8] && busy) begin ok = 1; break; end
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, actual running required finished");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      bit ok;
      for (int i = 0; i < 256; i++) nack_left[i] = 0;
      for (int i = 0; i < 16; i++) tbl_mem[i] = 16'h0000;
      set_fixed(0, 0, 0);

      repeat (3) @(negedge clock);
      chk("rst_device_address", device_address, 9'h034);
      chk("rst_tbl_addr", tbl_addr, 0);
      chk("rst_reg_data", {i2c_reg_address, i2c_data}, 16'h0000);
      chk("rst_flags", {busy, done, error}, 3'b000);
      chk("rst_error_code", error_code, 2'b00);
      chk("rst_fail_index", fail_index, 0);
      @(posedge clock); #1; reset = 1'b1;

      // all entries acked
      set_fixed(0, 0, 0);
      run_pass(1, 1, "all_ack");
      chk("all_ack_count", obs_q.size(), 3);
      chk("all_ack_first", obs_q[0], 16'h0F00);
      chk("all_ack_last", obs_q[2], 16'h1201);

      // entry 1 NACKed once
      set_fixed(0, 1, 0);
      run_pass(1, 1, "nack_once");
      chk("nack_once_count", obs_q.size(), 4);
      chk("nack_once_retry_bytes", obs_q[2], 16'h0C00);

      // entry 2 always NACKed
      set_fixed(0, 0, 99);
      run_pass(1, 1, "nack_always");
      chk("nack_always_count", obs_q.size(), 5);
      chk("nack_always_code", error_code, 2'b01);
      chk("nack_always_index", fail_index, 2);

      // engine never accepts, then a fresh start recovers
      set_fixed(0, 0, 0);
      run_pass(0, 1, "accept_timeout");
      chk("accept_timeout_go_len", last_go_len, TMO);
      chk("accept_timeout_code", error_code, 2'b10);
      run_pass(1, 1, "after_accept_timeout");
      chk("after_timeout_first", obs_q[0], 16'h0F00);

      // engine accepts but never finishes; a late WE in FAIL is ignored
      run_pass(1, 0, "done_timeout");
      chk("done_timeout_code", error_code, 2'b11);
      we_en = 1;
      repeat (10) @(negedge clock);
      chk("late_we_error", error, 1);
      chk("late_we_code", error_code, 2'b11);
      chk("late_we_busy", busy, 0);

      // stray start pulses while busy and stray WE in WAIT_ACCEPT
      set_fixed(0, 1, 0);
      stray_mode = 1; acc_min = 6;
      run_pass(1, 1, "stray");
      chk("stray_count", obs_q.size(), 4);
      stray_mode = 0; acc_min = 0;

      // asynchronous reset while waiting for entry 1 to finish
      set_fixed(0, 0, 0);
      load_table();
      accept_en = 1; we_en = 1;
      exp_q.delete(); exp_q.push_back(tbl[0]); exp_q.push_back(tbl[1]);
      have_we = 0;
      pulse_start();
      wait_cond_addr1(ok);
      chk("reset_reach_entry1", ok, 1);
      we_en = 0;
      wait_wait_done(ok);
      chk("reset_reach_wait_done", ok, 1);
      repeat (3) @(negedge clock);
      chk("pre_reset_tbl_addr", tbl_addr, 1);
      chk("pre_reset_reg", i2c_reg_address, 8'h0C);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_device_address", device_address, 9'h034);
      chk("async_rst_tbl_addr", tbl_addr, 0);
      chk("async_rst_reg_data", {i2c_reg_address, i2c_data}, 16'h0000);
      chk("async_rst_flags", {busy, done, error}, 3'b000);
      chk("async_rst_code_index", {error_code, fail_index}, 6'h00);
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      chk("reset_requests_seen", exp_q.size(), 0);
      run_pass(1, 1, "after_reset");
      chk("after_reset_first", obs_q[0], 16'h0F00);

      // randomized tables and NACK patterns
      for (int r = 0; r < 6; r++) begin
         for (int j = 0; j < N; j++) begin
            int pick;
            tbl[j] = {8'((j << 4) | $urandom_range(1, 15)), 8'($urandom_range(0, 255))};
            pick = $urandom_range(0, 9);
            nacks[j] = (pick < 5) ? 0 : (pick < 7) ? 1 : (pick < 8) ? 2 : (pick < 9) ? 3 : 0;
         end
         run_pass(1, 1, $sformatf("random%0d", r));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
